// File: rtl/pipelined_adder.sv
// ----------------------------------------------------------------------------
// pipelined_adder
//
// Pipelined WIDTH-bit adder/subtractor. The carry chain is split into STAGES
// chunks of CHUNK = WIDTH/STAGES bits. Each chunk has one register stage. Stage
// k adds operand bits [k*CHUNK +: CHUNK] using the carry registered by stage
// k-1. Stage 0 uses the effective carry-in.
//
// Operand bits that have not been consumed yet travel forward with each
// operation, and so do the sum chunks that are already complete. Sum,
// carry-out and overflow therefore appear together in the last stage. The
// forwarded operand field narrows by CHUNK bits per stage, and the sum field
// widens by CHUNK bits per stage.
//
// WIDTH must be a multiple of STAGES. STAGES=1 gives a single registered
// adder with latency 1.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; clears all valid bits and the
//                result registers
//   in_valid_i   operands present
//   in_ready_o   operands accepted this cycle (equals the advance condition)
//   a_i, b_i     operands
//   ci_i         carry-in for add, borrow-in for subtract
//   sub_i        0 = a + b + ci, 1 = a - b - ci
//   out_valid_o  result present
//   out_ready_i  consumer takes the result this cycle
//   s_o          sum / difference
//   co_o         carry-out; in subtract mode 1 means no borrow
//   ovf_o        two's-complement signed overflow
// ----------------------------------------------------------------------------
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] s_o,
    output logic             co_o,
    output logic             ovf_o
);

    localparam int CHUNK = WIDTH / STAGES;

    // The whole pipe moves as one. A stalled result freezes every stage, and
    // bubbles stay where they are.
    logic adv;

    logic ovf_d;
    logic ovf_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be consumed when entering this stage.
        localparam int OPW = WIDTH - k * CHUNK;
        // Sum bits that are complete once this stage has registered.
        localparam int SW  = (k + 1) * CHUNK;

        logic [OPW-1:0]   a_in;
        logic [OPW-1:0]   bx_in;
        logic             c_in;
        logic [CHUNK:0]   part;

        logic             v_d;
        logic             v_q;
        logic             c_d;
        logic             c_q;
        logic [SW-1:0]    sum_d;
        logic [SW-1:0]    sum_q;

        if (k == 0) begin : g_head
            // Subtraction is performed as a + ~b + !ci. The inversion is
            // applied once here, so later stages only ever add.
            assign a_in  = a_i;
            assign bx_in = b_i ^ {WIDTH{sub_i}};
            assign c_in  = ci_i ^ sub_i;
            assign v_d   = in_valid_i;
            assign sum_d = part[CHUNK-1:0];
        end else begin : g_body
            assign a_in  = g_stage[k-1].g_fwd.a_q;
            assign bx_in = g_stage[k-1].g_fwd.bx_q;
            assign c_in  = g_stage[k-1].c_q;
            assign v_d   = g_stage[k-1].v_q;
            assign sum_d = {part[CHUNK-1:0], g_stage[k-1].sum_q};
        end

        assign part = {1'b0, a_in[CHUNK-1:0]}
                    + {1'b0, bx_in[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, c_in};
        assign c_d  = part[CHUNK];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                v_q   <= v_d;
                c_q   <= c_d;
                sum_q <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // Upper operand chunks that are still waiting for their stage.
            logic [OPW-CHUNK-1:0] a_q;
            logic [OPW-CHUNK-1:0] bx_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q  <= '0;
                    bx_q <= '0;
                end else if (adv) begin
                    a_q  <= a_in[OPW-1:CHUNK];
                    bx_q <= bx_in[OPW-1:CHUNK];
                end
            end
        end else begin : g_last
            // Carry into the MSB is recovered as a ^ b ^ s at that bit. This
            // also works when CHUNK is 1.
            assign ovf_d = a_in[CHUNK-1] ^ bx_in[CHUNK-1]
                         ^ part[CHUNK-1] ^ part[CHUNK];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign out_valid_o = g_stage[STAGES-1].v_q;
    assign s_o         = g_stage[STAGES-1].sum_q;
    assign co_o        = g_stage[STAGES-1].c_q;
    assign ovf_o       = ovf_q;

    assign adv        = ~out_valid_o | out_ready_i;
    assign in_ready_o = adv;

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined WIDTH-bit adder/subtractor; generalised successor of the team's single-bit full adder cell.
- Carry chain split into STAGES equal chunks, one register stage per chunk.
- Throughput one operation per clock; valid/ready handshake on both sides.
- Used wherever a wide add/sub must close timing in the datapath.

Parameters:
- WIDTH, 16, operand/result width in bits.
- STAGES, 4, pipeline depth and number of carry chunks; WIDTH % STAGES == 0 required; STAGES=1 legal.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  sum/difference.
- co  output  1  carry-out; in sub mode 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Arithmetic:
  - sub=0: {co,s} = a + b + ci.
  - sub=1: {co,s} = a + ~b + !ci, i.e. s = a - b - ci mod 2^WIDTH.
  - ovf = carry into MSB XOR carry out of MSB.
- Chunking: C = WIDTH/STAGES.
  - Stage k (0-based) adds bits [k*C +: C] using the carry registered by stage k-1; stage 0 uses the effective carry-in.
  - Unconsumed upper operand chunks and completed lower sum chunks travel with the operation, so s, co and ovf present aligned in the final stage.
- Latency: an operation accepted at edge N (in_valid & in_ready) makes out_valid high after edge N+STAGES-1 (visible in the cycle after that edge), provided there is no stall.
- Advance condition: adv = !out_valid | out_ready.
  - All stages (data and per-stage valid bits) shift only when adv=1.
  - When adv=0, every register holds.
- in_ready = adv (combinational).
  - Bubbles are not collapsed during a stall.
  - An accept with adv=1 always enters stage 0.
- Output hold: while out_valid=1 and out_ready=0, s/co/ovf stay stable.
- Ordering: results emerge in acceptance order; no drop, no duplication.
- Concurrency: acceptance at the input and removal at the output happen in the same cycle with no conflict.
- Idle stages: data registers may hold stale data; only the valid bits are significant.
- Reset (rst_n low, any time, including mid-operation):
  - All valid bits clear immediately: out_valid=0.
  - s, co, ovf = 0.
  - in_ready = 1 once reset is released.
  - In-flight operations are discarded; no result from them ever appears.
- STAGES=1: single register stage; latency 1; the same handshake applies.
- Inputs a, b, ci, sub are sampled only on accept; their values are don't-care otherwise.

Test Plan:
- WIDTH=16, STAGES=4, out_ready=1: a=0x1234, b=0x0FFF, ci=0, sub=0 -> s=0x2233, co=0, ovf=0, out_valid high exactly 4 edges after accept.
- Full carry ripple across all chunks: a=0xFFFF, b=0x0001, ci=0 -> s=0x0000, co=1, ovf=0. Then a=0x7FFF, b=0x0001 -> s=0x8000, co=0, ovf=1.
- Subtract: sub=1, a=0x0005, b=0x0007, ci=0 -> s=0xFFFE, co=0, ovf=0. Then sub=1, a=0x8000, b=0x0001, ci=1 -> s=0x7FFE, co=1, ovf=1.
- Back-to-back with stall:
  - Stimulus: issue 6 consecutive ops (a=i, b=0x0100, i=1..6); drop out_ready for 3 cycles after the first result.
  - Expect: in_ready low during the stall, s held at 0x0101 throughout, then results 0x0101..0x0106 in order with no gaps once out_ready returns.
- Reset mid-operation:
  - Stimulus: 3 ops in flight, pulse rst_n low for 1 cycle between clock edges.
  - Expect: out_valid=0 and s=0 immediately; no result appears within 10 cycles after release; a new op then completes with correct latency.
- STAGES=1, WIDTH=8: a=0xF0, b=0x20, ci=1 -> s=0x11, co=1, ovf=0, latency 1 edge; random 1000-op comparison against a reference model with random out_ready.
